// File: rtl/fp_custom_mult_rne.sv
// Floating-point multiplier for the {sign, exp, man} format with round-to-nearest-even,
// overflow saturation and underflow flush. Four-stage pipeline with a global stall
// driven by output backpressure.
module fp_custom_mult_rne #(
    parameter int unsigned ManWidth   = 16,
    parameter int unsigned ExpWidth   = 6,
    localparam int unsigned InOutWidth = 1 + ExpWidth + ManWidth
) (
    input  logic                  Clk_i,
    input  logic                  RstN_i,
    input  logic [InOutWidth-1:0] A_i,
    input  logic [InOutWidth-1:0] B_i,
    input  logic                  Nd_i,
    output logic                  Ready_o,
    output logic [InOutWidth-1:0] Result_o,
    output logic                  ResultValid_o,
    input  logic                  ResultReady_i,
    output logic                  Overflow_o,
    output logic                  Underflow_o
);

    localparam int unsigned ProdWidth = 2 * ManWidth + 2;
    localparam int unsigned ExpSWidth = ExpWidth + 2;
    localparam logic signed [ExpSWidth-1:0] Bias    = ExpSWidth'((1 << (ExpWidth - 1)) - 1);
    localparam logic signed [ExpSWidth-1:0] MaxExp  = ExpSWidth'((1 << ExpWidth) - 1);
    localparam logic signed [ExpSWidth-1:0] ExpZero = '0;

    logic stall;
    logic accept;

    // Stage 1: captured operands
    logic                s1Valid, s1Sign, s1Zero;
    logic [ExpWidth-1:0] s1ExpA, s1ExpB;
    logic [ManWidth-1:0] s1ManA, s1ManB;

    // Stage 2: raw product and unnormalised exponent
    logic                        s2Valid, s2Sign, s2Zero;
    logic [ProdWidth-1:0]        s2Prod;
    logic signed [ExpSWidth-1:0] s2Exp;

    // Stage 3: rounded mantissa and post-rounding exponent
    logic                        s3Valid, s3Sign, s3Zero;
    logic [ManWidth-1:0]         s3Man;
    logic signed [ExpSWidth-1:0] s3Exp;

    // Stage 4: output register
    logic                  resultValidQ, overflowQ, underflowQ;
    logic [InOutWidth-1:0] resultQ;

    assign stall   = resultValidQ & ~ResultReady_i;
    assign Ready_o = ~stall;
    assign accept  = Nd_i & Ready_o;

    // Stage 1 register: latch operands and flag zero/denormal inputs
    always_ff @(posedge Clk_i or negedge RstN_i) begin
        if (!RstN_i) begin
            s1Valid <= 1'b0;
            s1Sign  <= 1'b0;
            s1Zero  <= 1'b0;
            s1ExpA  <= '0;
            s1ExpB  <= '0;
            s1ManA  <= '0;
            s1ManB  <= '0;
        end else if (!stall) begin
            s1Valid <= accept;
            if (accept) begin
                s1Sign <= A_i[InOutWidth-1] ^ B_i[InOutWidth-1];
                s1Zero <= (A_i[InOutWidth-2 -: ExpWidth] == '0)
                        | (B_i[InOutWidth-2 -: ExpWidth] == '0);
                s1ExpA <= A_i[InOutWidth-2 -: ExpWidth];
                s1ExpB <= B_i[InOutWidth-2 -: ExpWidth];
                s1ManA <= A_i[ManWidth-1:0];
                s1ManB <= B_i[ManWidth-1:0];
            end
        end
    end

    logic [ProdWidth-1:0] mantA, mantB, prod;
    logic signed [ExpSWidth-1:0] expSum;

    // Stage 2 datapath: 1.m x 1.m and biased exponent sum
    always_comb begin
        mantA  = ProdWidth'({1'b1, s1ManA});
        mantB  = ProdWidth'({1'b1, s1ManB});
        prod   = mantA * mantB;
        expSum = ExpSWidth'(s1ExpA) + ExpSWidth'(s1ExpB) - Bias;
    end

    // Stage 2 register
    always_ff @(posedge Clk_i or negedge RstN_i) begin
        if (!RstN_i) begin
            s2Valid <= 1'b0;
            s2Sign  <= 1'b0;
            s2Zero  <= 1'b0;
            s2Prod  <= '0;
            s2Exp   <= '0;
        end else if (!stall) begin
            s2Valid <= s1Valid;
            s2Sign  <= s1Sign;
            s2Zero  <= s1Zero;
            s2Prod  <= prod;
            s2Exp   <= expSum;
        end
    end

    logic [ProdWidth-1:0]        shifted;
    logic [ManWidth-1:0]         field;
    logic                        guard, sticky, roundUp;
    logic [ManWidth:0]           rounded;
    logic signed [ExpSWidth-1:0] expNorm, expRnd;

    // Stage 3 datapath: normalise so the hidden 1 sits at the top, then round half-to-even
    always_comb begin
        shifted = s2Prod[ProdWidth-1] ? s2Prod : (s2Prod << 1);
        field   = shifted[ProdWidth-2 -: ManWidth];
        guard   = shifted[ManWidth];
        sticky  = |shifted[ManWidth-1:0];
        expNorm = s2Exp + ExpSWidth'(s2Prod[ProdWidth-1]);
        roundUp = guard & (sticky | field[0]);
        rounded = {1'b0, field} + (ManWidth+1)'(roundUp);
        // A carry out leaves the mantissa bits at zero, i.e. exactly 2.0 -> 1.0 x 2
        expRnd  = expNorm + ExpSWidth'(rounded[ManWidth]);
    end

    // Stage 3 register
    always_ff @(posedge Clk_i or negedge RstN_i) begin
        if (!RstN_i) begin
            s3Valid <= 1'b0;
            s3Sign  <= 1'b0;
            s3Zero  <= 1'b0;
            s3Man   <= '0;
            s3Exp   <= '0;
        end else if (!stall) begin
            s3Valid <= s2Valid;
            s3Sign  <= s2Sign;
            s3Zero  <= s2Zero;
            s3Man   <= rounded[ManWidth-1:0];
            s3Exp   <= expRnd;
        end
    end

    logic [InOutWidth-1:0] resultD;
    logic                  overflowD, underflowD;

    // Stage 4 datapath: zero input, flush, saturate or pass the finite value
    always_comb begin
        resultD    = {s3Sign, {(InOutWidth-1){1'b0}}};
        overflowD  = 1'b0;
        underflowD = 1'b0;
        if (s3Zero) begin
            resultD = {s3Sign, {(InOutWidth-1){1'b0}}};
        end else if (s3Exp <= ExpZero) begin
            underflowD = 1'b1;
        end else if (s3Exp > MaxExp) begin
            resultD   = {s3Sign, {(InOutWidth-1){1'b1}}};
            overflowD = 1'b1;
        end else begin
            resultD = {s3Sign, s3Exp[ExpWidth-1:0], s3Man};
        end
    end

    // Output register; data only reloads for real results so bubbles leave it untouched
    always_ff @(posedge Clk_i or negedge RstN_i) begin
        if (!RstN_i) begin
            resultValidQ <= 1'b0;
            resultQ      <= '0;
            overflowQ    <= 1'b0;
            underflowQ   <= 1'b0;
        end else if (!stall) begin
            resultValidQ <= s3Valid;
            if (s3Valid) begin
                resultQ    <= resultD;
                overflowQ  <= overflowD;
                underflowQ <= underflowD;
            end
        end
    end

    assign Result_o      = resultQ;
    assign ResultValid_o = resultValidQ;
    assign Overflow_o    = overflowQ;
    assign Underflow_o   = underflowQ;

endmodule
